// File: rtl/piso_frame_pkg.sv
// Shared definitions for the serial frame transmitter.
// State encoding and default frame shape.
package piso_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } state_e;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_PARITY   = 0;
    localparam int DEF_IDLE_LVL = 1;

endpackage

// File: rtl/dff_ne_clr.sv
// Negative-edge D flip-flop, async active-low clear.
// The clear value is a parameter so one cell serves every register.
module dff_ne_clr #(
    parameter int           W       = 1,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         c,
    input  logic         clr_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture d on the falling edge; clear forces CLR_VAL at once.
    always_ff @(negedge c or negedge clr_n) begin
        if (!clr_n) q <= CLR_VAL;
        else        q <= d;
    end

endmodule

// File: rtl/piso_frame_tx.sv
// Parallel-in serial-out frame transmitter:
// start bit, data LSB first, optional even parity, stop bit.
module piso_frame_tx
    import piso_frame_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int PARITY   = DEF_PARITY,
    parameter int IDLE_LVL = DEF_IDLE_LVL
) (
    input  logic             C,
    input  logic             CLRnot,
    input  logic [WIDTH-1:0] D_IN,
    input  logic             LOAD,
    output logic             READY,
    output logic             SO,
    output logic             BUSY,
    output logic             DONE
);

    localparam int            CW       = $clog2(WIDTH) + 1;
    localparam logic          IDLE_BIT = (IDLE_LVL != 0) ? 1'b1 : 1'b0;
    localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);

    logic [2:0]       state_q;
    state_e           state;
    state_e           state_n;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_n;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_n;
    logic             par_q;
    logic             par_n;
    logic             so_n;
    logic             done_n;
    logic             accept;

    assign state  = state_e'(state_q);
    assign READY  = (state == ST_IDLE) || (state == ST_STOP);
    assign BUSY   = (state != ST_IDLE);
    assign accept = LOAD && READY;

    // Next state, shift register, counter and parity capture.
    always_comb begin
        state_n = state;
        shreg_n = shreg_q;
        cnt_n   = cnt_q;
        par_n   = par_q;
        case (state)
            ST_IDLE:  state_n = ST_IDLE;
            ST_START: begin
                state_n = ST_DATA;
                cnt_n   = '0;
            end
            ST_DATA: begin
                shreg_n = shreg_q >> 1;
                if (cnt_q == LAST) begin
                    cnt_n   = '0;
                    state_n = (PARITY != 0) ? ST_PAR : ST_STOP;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            ST_PAR:   state_n = ST_STOP;
            ST_STOP:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
        if (accept) begin
            state_n = ST_START;
            shreg_n = D_IN;
            par_n   = ^D_IN;
        end
    end

    // Line level for the upcoming state, so SO lines up with state.
    always_comb begin
        so_n   = IDLE_BIT;
        done_n = (state == ST_STOP);
        case (state_n)
            ST_START: so_n = ~IDLE_BIT;
            ST_DATA:  so_n = shreg_n[0];
            ST_PAR:   so_n = par_n;
            default:  so_n = IDLE_BIT;
        endcase
    end

    dff_ne_clr #(.W(3), .CLR_VAL(ST_IDLE)) u_state (
        .c(C), .clr_n(CLRnot), .d(state_n), .q(state_q)
    );

    dff_ne_clr #(.W(1), .CLR_VAL(IDLE_BIT)) u_so (
        .c(C), .clr_n(CLRnot), .d(so_n), .q(SO)
    );

    dff_ne_clr #(.W(1), .CLR_VAL(1'b0)) u_done (
        .c(C), .clr_n(CLRnot), .d(done_n), .q(DONE)
    );

    dff_ne_clr #(.W(WIDTH), .CLR_VAL('0)) u_shreg (
        .c(C), .clr_n(CLRnot), .d(shreg_n), .q(shreg_q)
    );

    dff_ne_clr #(.W(CW), .CLR_VAL('0)) u_cnt (
        .c(C), .clr_n(CLRnot), .d(cnt_n), .q(cnt_q)
    );

    dff_ne_clr #(.W(1), .CLR_VAL(1'b0)) u_par (
        .c(C), .clr_n(CLRnot), .d(par_n), .q(par_q)
    );

endmodule
